// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader.
//   Control : start, base_addr, len (in)    busy, done (out)
//   BRAM    : rd_dout (in)                  rd_addr (out)
//   Stream  : m_ready (in)                  m_data, m_valid, m_last (out)
// The master modport is the reader. The slave modport is the surrounding logic
// that drives the control inputs, the BRAM model and the stream sink.
interface bram_stream_reader_if #(
    parameter int unsigned D_SIZE  = 64,
    parameter int unsigned Q_DEPTH = 8
);
    logic               start;
    logic [Q_DEPTH-1:0] base_addr;
    logic [Q_DEPTH:0]   len;
    logic               busy;
    logic               done;
    logic [Q_DEPTH-1:0] rd_addr;
    logic [D_SIZE-1:0]  rd_dout;
    logic [D_SIZE-1:0]  m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;

    modport master (
        input  start, base_addr, len, rd_dout, m_ready,
        output busy, done, rd_addr, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, len, rd_dout, m_ready,
        input  busy, done, rd_addr, m_data, m_valid, m_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads len consecutive words from a 1-cycle-latency BRAM
// read port, starting at base_addr and wrapping modulo 2**Q_DEPTH. The words
// are streamed out through a 2-entry output FIFO that is backpressure safe.
// Ports: clk, rst_n (synchronous, active-low), bus (bram_stream_reader_if.master).
// Optional feature: define BRAM_RD_LAST_EN to drive m_last on the final beat of
// each burst. When it is undefined, m_last is tied to 0.
module bram_stream_reader #(
    parameter int unsigned D_SIZE  = 64,
    parameter int unsigned Q_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bram_stream_reader_if.master  bus
);
    localparam int unsigned L_W = Q_DEPTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t            state;
    logic [L_W-1:0]    rem;         // addresses still to issue
    logic              pend;        // read issued last cycle, data on rd_dout now
    logic [D_SIZE-1:0] tail_data;   // second FIFO entry; the head is m_data/m_valid
    logic              tail_valid;

    logic [1:0]        load_c;
    logic              pop_c;
    logic              issue_c;
    logic              last_issue_c;

    // Flow control: a read is issued only if its word is sure to find a FIFO slot.
    always_comb begin
        pop_c        = bus.m_valid & bus.m_ready;
        load_c       = 2'(bus.m_valid) + 2'(tail_valid) + 2'(pend);
        issue_c      = (state == RUN) && ((load_c - 2'(pop_c)) < 2'd2);
        last_issue_c = issue_c && (rem == L_W'(1));
    end

    // Burst control FSM. rd_addr holds the next address to issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            bus.rd_addr <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.rd_addr <= bus.base_addr;
                        rem         <= bus.len;
                        if (bus.len == '0) begin
                            state    <= FIN;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue_c) begin
                        rem <= rem - L_W'(1);
                        // The last address stays on rd_addr after it is issued.
                        if (last_issue_c) begin
                            state <= DRAIN;
                        end else begin
                            bus.rd_addr <= bus.rd_addr + Q_DEPTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The final word transfers when it is the only one left in the pipe.
                    if (pop_c && !tail_valid && !pend) begin
                        state    <= FIN;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read capture and 2-entry FIFO. The head entry drives the stream outputs directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend        <= 1'b0;
            tail_valid  <= 1'b0;
            tail_data   <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            pend <= issue_c;
            if (pop_c || !bus.m_valid) begin
                if (tail_valid) begin
                    bus.m_data  <= tail_data;
                    bus.m_valid <= 1'b1;
                    tail_valid  <= pend;
                    if (pend) begin
                        tail_data <= bus.rd_dout;
                    end
                end else begin
                    bus.m_valid <= pend;
                    if (pend) begin
                        bus.m_data <= bus.rd_dout;
                    end
                end
            end else if (pend) begin
                tail_data  <= bus.rd_dout;
                tail_valid <= 1'b1;
            end
        end
    end

`ifdef BRAM_RD_LAST_EN
    logic pend_last;
    logic tail_last;

    // The last flag follows its word through the same pipe and FIFO as the data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_last  <= 1'b0;
            tail_last  <= 1'b0;
            bus.m_last <= 1'b0;
        end else begin
            pend_last <= last_issue_c;
            if (pop_c || !bus.m_valid) begin
                if (tail_valid) begin
                    bus.m_last <= tail_last;
                    tail_last  <= pend_last;
                end else begin
                    bus.m_last <= pend_last;
                end
            end else if (pend) begin
                tail_last <= pend_last;
            end
        end
    end
`else
    assign bus.m_last = 1'b0;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a BRAM model with RAM[i]=i, a
// queue-based reference model and directed bursts.
module tb_bram_stream_reader;
    localparam int unsigned D = 64;
    localparam int unsigned Q = 8;
`ifdef BRAM_RD_LAST_EN
    localparam bit LAST_EN = 1'b1;
`else
    localparam bit LAST_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    bram_stream_reader_if #(.D_SIZE(D), .Q_DEPTH(Q)) bus ();

    bram_stream_reader #(.D_SIZE(D), .Q_DEPTH(Q)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [D-1:0] ram [0:(1<<Q)-1];

    // BRAM read port: data appears one cycle after the address.
    always @(posedge clk) bus.rd_dout <= ram[bus.rd_addr];

    int checks   = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model (evaluated on the falling edge) -----------
    typedef struct {
        logic [D-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    beat_t        nb;
    int           cyc        = 0;
    bit           active     = 1'b0;
    bit           exp_done   = 1'b0;
    bit           exp_busy   = 1'b0;
    bit           rst_seen   = 1'b0;
    bit           stall_prev = 1'b0;
    logic [D-1:0] stall_data = '0;
    bit           full_rate  = 1'b0;
    int           fr_lo      = 0;
    int           fr_hi      = 0;
    int           beats      = 0;
    int           dones      = 0;

    always @(negedge clk) begin : cmp
        bit           idle;
        bit           nxt_done;
        logic [Q-1:0] a;
        cyc++;
        if (rst_seen) begin
            chk1 ("rst_m_valid", bus.m_valid, 1'b0);
            chk1 ("rst_m_last",  bus.m_last,  1'b0);
            chk64("rst_m_data",  64'(bus.m_data), 64'(0));
            chk64("rst_rd_addr", 64'(bus.rd_addr), 64'(0));
        end
        chk1("busy", bus.busy, exp_busy);
        chk1("done", bus.done, exp_done);
        if (bus.done) dones++;
        if (full_rate) chk1("valid_timing", bus.m_valid, (cyc >= fr_lo) && (cyc < fr_hi));
        if (stall_prev && !rst_seen) begin
            chk1 ("stall_valid", bus.m_valid, 1'b1);
            chk64("stall_data", 64'(bus.m_data), 64'(stall_data));
        end
        if (bus.m_valid) begin
            if (exp_q.size() == 0) begin
                chk1("spurious_valid", bus.m_valid, 1'b0);
            end else begin
                chk64("m_data", 64'(bus.m_data), 64'(exp_q[0].data));
                chk1 ("m_last", bus.m_last, LAST_EN & exp_q[0].last);
            end
        end else begin
            chk1("m_last_idle", bus.m_last, 1'b0);
        end

        // Predict what the next rising edge does.
        nxt_done   = 1'b0;
        idle       = !active && !exp_done;
        stall_prev = bus.m_valid && !bus.m_ready;
        stall_data = bus.m_data;
        if (!rst_n) begin
            exp_q.delete();
            active     = 1'b0;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            stall_prev = 1'b0;
            rst_seen   = 1'b1;
            fr_lo      = 0;
            fr_hi      = 0;
        end else begin
            rst_seen = 1'b0;
            if (bus.m_valid && bus.m_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                beats++;
                if (exp_q.size() == 0 && active) begin
                    nxt_done = 1'b1;
                    active   = 1'b0;
                end
            end
            if (bus.start && idle) begin
                if (bus.len == '0) begin
                    nxt_done = 1'b1;
                end else begin
                    for (int i = 0; i < int'(bus.len); i++) begin
                        a       = bus.base_addr + Q'(i);
                        nb.data = ram[a];
                        nb.last = (i == int'(bus.len) - 1);
                        exp_q.push_back(nb);
                    end
                    active = 1'b1;
                    fr_lo  = cyc + 3;
                    fr_hi  = cyc + 3 + int'(bus.len);
                end
            end
            exp_done = nxt_done;
            exp_busy = active;
        end
    end

    // ---------------- stimulus ---------------------------------------------------
    task automatic pulse_start(input int b, input int l);
        @(posedge clk); #2;
        bus.start     = 1'b1;
        bus.base_addr = Q'(b);
        bus.len       = (Q+1)'(l);
        @(posedge clk); #2;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(posedge clk); #2;
            if (bus.done) seen = 1'b1;
        end
        chk1("done_seen", seen, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1);
    end

    initial begin
        int b0;
        logic [63:0] exp4 [4];
        exp4[0] = 64'd254; exp4[1] = 64'd255; exp4[2] = 64'd0; exp4[3] = 64'd1;
        for (int i = 0; i < (1 << Q); i++) ram[i] = D'(i);
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.m_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // base 4, len 5, full rate: data 4..8 from start+2, done at start+7
        full_rate = 1'b1;
        pulse_start(4, 5);
        @(negedge clk);
        chk1("t1_busy", bus.busy, 1'b1);
        chk1("t1_valid_e0", bus.m_valid, 1'b0);
        @(negedge clk);
        chk1("t1_valid_e1", bus.m_valid, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1 ("t1_valid", bus.m_valid, 1'b1);
            chk64("t1_data", 64'(bus.m_data), 64'(4 + k));
            chk1 ("t1_last", bus.m_last, LAST_EN && (k == 4));
        end
        @(negedge clk);
        chk1("t1_done", bus.done, 1'b1);
        chk1("t1_busy_fin", bus.busy, 1'b0);
        chk1("t1_valid_fin", bus.m_valid, 1'b0);
        @(negedge clk);
        chk1("t1_done_once", bus.done, 1'b0);

        // wrap-around: 254,255,0,1 back to back
        pulse_start(254, 4);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1 ("t2_valid", bus.m_valid, 1'b1);
            chk64("t2_data", 64'(bus.m_data), exp4[k]);
        end
        wait_done(10);

        // backpressure: ready pattern 1,0,0 repeating
        full_rate = 1'b0;
        b0 = beats;
        pulse_start(10, 5);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 100 && !seen; i++) begin
                @(posedge clk); #2;
                if (bus.done) seen = 1'b1;
                bus.m_ready = (i % 3 == 0);
            end
            chk1("t3_done_seen", seen, 1'b1);
        end
        bus.m_ready = 1'b1;
        chk64("t3_beats", 64'(beats - b0), 64'(5));
        @(posedge clk); #2;
        full_rate = 1'b1;

        // len 0: done the cycle after start, never busy or valid
        pulse_start(7, 0);
        @(negedge clk);
        chk1("t4_done", bus.done, 1'b1);
        chk1("t4_busy", bus.busy, 1'b0);
        chk1("t4_valid", bus.m_valid, 1'b0);
        @(negedge clk);
        chk1("t4_done_off", bus.done, 1'b0);
        chk1("t4_busy_off", bus.busy, 1'b0);

        // reset after the second beat of a len 8 burst, then a fresh len 2 burst
        b0 = beats;
        pulse_start(20, 8);
        repeat (3) @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1 ("t5_valid", bus.m_valid, 1'b0);
        chk1 ("t5_busy", bus.busy, 1'b0);
        chk1 ("t5_done", bus.done, 1'b0);
        chk64("t5_beats", 64'(beats - b0), 64'(2));
        @(posedge clk); #2;
        rst_n = 1'b1;
        b0 = beats;
        pulse_start(100, 2);
        wait_done(10);
        chk64("t5_new_beats", 64'(beats - b0), 64'(2));

        // start during RUN with a different base is ignored
        b0 = beats;
        pulse_start(30, 6);
        @(posedge clk); #2;
        pulse_start(60, 3);
        wait_done(20);
        chk64("t6_beats", 64'(beats - b0), 64'(6));
        repeat (5) @(posedge clk);
        #2;
        chk1("t6_busy_idle", bus.busy, 1'b0);
        chk1("t6_valid_idle", bus.m_valid, 1'b0);
        chk64("done_count", 64'(dones), 64'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter D_SIZE, default 64: word width in bits, matching the attached bram_p.
REQ-002 SHALL have parameter Q_DEPTH, default 8: address width; Q_SIZE = 1 << Q_DEPTH words.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1: one-cycle request to begin a read burst.
REQ-006 SHALL have port base_addr  input  Q_DEPTH: first word address, sampled when start is accepted.
REQ-007 SHALL have port len  input  Q_DEPTH+1: number of words to read (0..Q_SIZE), sampled when start is accepted.
REQ-008 SHALL have port busy  output  1: high from the cycle after start is accepted until the cycle done is pulsed.
REQ-009 SHALL have port done  output  1: one-cycle pulse after the last word is accepted downstream.
REQ-010 SHALL have port rd_addr  output  Q_DEPTH: read address driven to the bram_p read port.
REQ-011 SHALL have port rd_dout  input  D_SIZE: bram_p read data, valid one cycle after the address is presented.
REQ-012 SHALL have port m_data  output  D_SIZE: stream data out.
REQ-013 SHALL have port m_valid  output  1: stream data valid.
REQ-014 SHALL have port m_ready  input  1: downstream accept; a beat transfers when m_valid and m_ready are both high.
REQ-015 SHALL have port m_last  output  1: marks the final beat of a burst (see Configuration).

Function
REQ-016 SHALL implement the states IDLE, RUN, DRAIN and FIN; start is accepted only in IDLE and is ignored in all other states.
REQ-017 SHALL, on start in IDLE with len=0, go to FIN and pulse done in the next cycle without asserting m_valid.
REQ-018 SHALL, on start in IDLE with len>0, go to RUN and issue addresses base_addr, base_addr+1, ... modulo Q_SIZE; wrap-around from Q_SIZE-1 to 0 is legal.
REQ-019 SHALL treat an address as issued in cycle t when rd_addr carries it and the internal issue flag is set, and SHALL capture rd_dout in cycle t+1.
REQ-020 SHALL hold captured words in a 2-entry output FIFO, and SHALL drive m_valid and m_data from the FIFO head.
REQ-021 SHALL issue an address only when FIFO occupancy plus in-flight reads minus the pop in the current cycle is less than 2, so no word is ever dropped under backpressure.
REQ-022 SHALL, with m_ready held high, sustain one beat per cycle; the first m_valid SHALL appear 2 cycles after start.
REQ-023 SHALL keep m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-024 SHALL enter DRAIN after the last address is issued, and SHALL enter FIN on the cycle the last beat transfers.
REQ-025 SHALL, in FIN, assert done for exactly one cycle, deassert busy, and return to IDLE; start in that cycle is ignored.
REQ-026 SHALL hold rd_addr at its last value when not issuing.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, go to IDLE and flush the FIFO and in-flight state, including mid-burst; no done pulse is produced for an aborted burst.
REQ-028 SHALL have the following reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, rd_addr=0.

Configuration
REQ-029 SHALL, when macro BRAM_RD_LAST_EN is defined, assert m_last together with m_valid on the final beat of each burst, carried per FIFO entry.
REQ-030 SHALL, when BRAM_RD_LAST_EN is undefined, tie m_last to 0 and remove its tracking logic; all other behaviour is unchanged.

Verification
REQ-031 SHALL cover: RAM[i]=i, base_addr=4, len=5, m_ready=1 -> data 4,5,6,7,8 on 5 consecutive cycles from start+2; done at start+7; m_last on 8 (with macro).
REQ-032 SHALL cover: base_addr=254, len=4, Q_DEPTH=8 -> addresses 254,255,0,1 in order, no gap.
REQ-033 SHALL cover: len=5, m_ready toggling 1,0,0,1,... -> all 5 words in order, none lost or duplicated, m_data stable while stalled.
REQ-034 SHALL cover: len=0 -> done one cycle after start, m_valid never high; busy stays 0.
REQ-035 SHALL cover: rst_n=0 after the 2nd beat of len=8 -> the next cycle shows m_valid=0, busy=0; a new start with len=2 then returns the correct 2 words.
REQ-036 SHALL cover: start pulsed during RUN with different base_addr -> ignored; original burst completes unchanged.
